// File: rtl/dnu3_ctrl_pkg.sv
// Purpose: shared definitions for the DNU3 IB-RAM iteration-update handshake.
//   - state_e   : reader FSM state encoding (also exported on the debug port)
//   - BUSY_*    : writer status codes carried on busy[1:0]
//   - is_hs_state(): true for the states that wait on the writer and are
//                    therefore guarded by the handshake timeout
package dnu3_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_REQ     = 3'b001,
    ST_UPD     = 3'b010,
    ST_DROP    = 3'b011,
    ST_RD      = 3'b100,
    ST_RD_LAST = 3'b101,
    ST_TERM    = 3'b110,
    ST_ERR     = 3'b111
  } state_e;

  localparam logic [1:0] BUSY_IDLE = 2'b00;
  localparam logic [1:0] BUSY_UPD  = 2'b01;
  localparam logic [1:0] BUSY_FIN  = 2'b10;

  function automatic logic is_hs_state(input state_e s);
    return (s == ST_REQ) || (s == ST_UPD) || (s == ST_DROP);
  endfunction

endpackage

// File: rtl/dnu3_hs_timer.sv
// Purpose: per-phase handshake timeout counter.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   clr_i      : high on the first cycle of a new phase; that cycle counts as 0
//   en_i       : count while high; the counter idles at 0 when low
//   expired_o  : high on the LIMIT-th consecutive enabled cycle of a phase
module dnu3_hs_timer #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_eff;

  // clr_i arrives registered together with the new state, so it overrides the
  // stale count in the same cycle rather than one cycle late.
  assign cnt_eff   = clr_i ? '0 : cnt_q;
  assign expired_o = en_i && (cnt_eff == W'(LIMIT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_eff + W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/dnu3_rd_fsm.sv
// Purpose: reader/initiator side of the DNU3 IB-RAM iteration-update handshake.
//   Per decoding iteration: request an IB-RAM refresh from the writer, follow
//   its busy status through update and finish, then sweep both interleaved
//   banks for LOAD_CYCLE cycles. Terminates on syndrome pass or MAX_ITER.
// Ports:
//   read_clk, rst        : clock, synchronous active-high reset
//   dec_start            : 1-cycle pulse, starts a decode (only honoured in IDLE)
//   syndrome_ok          : parity satisfied, sampled only in RD_LAST
//   busy[1:0]            : writer status (00 idle, 01 updating, 10 finish)
//   iter_rqst            : request to writer, high in REQ and UPD
//   iter_termination     : 1-cycle pulse to writer in TERM or ERR
//   ram_read_en, rd_addr : shared IB-RAM read port for both banks
//   iter_cnt             : completed iterations of the current decode
//   decode_done          : 1-cycle pulse on normal termination
//   handshake_err        : sticky handshake failure flag
//   state                : current FSM state (debug)
// Handshake: iter_rqst rises on REQ entry and stays high until the writer
//   reports finish (busy==10); the writer reads a falling iter_rqst as its own
//   finish, so it only falls in DROP, ERR or on reset. Reads start only after
//   the writer has returned to busy==00.
module dnu3_rd_fsm
  import dnu3_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_CYCLE = 64,
  parameter int unsigned MAX_ITER   = 10,
  parameter int unsigned HS_TIMEOUT = 256,
  localparam int unsigned AW = $clog2(LOAD_CYCLE),
  localparam int unsigned CW = $clog2(MAX_ITER + 1)
) (
  input  logic          read_clk,
  input  logic          rst,
  input  logic          dec_start,
  input  logic          syndrome_ok,
  input  logic [1:0]    busy,
  output logic          iter_rqst,
  output logic          iter_termination,
  output logic          ram_read_en,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] iter_cnt,
  output logic          decode_done,
  output logic          handshake_err,
  output logic [2:0]    state
);

  state_e        state_q;
  logic          st_new_q;
  logic          iter_rqst_q;
  logic          iter_term_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic [CW-1:0] iter_cnt_q;
  logic          done_q;
  logic          err_q;

  logic          hs_en;
  logic          hs_expired;

  assign hs_en = is_hs_state(state_q);

  dnu3_hs_timer #(
    .LIMIT(HS_TIMEOUT)
  ) u_hs_timer (
    .clk_i    (read_clk),
    .rst_i    (rst),
    .clr_i    (st_new_q),
    .en_i     (hs_en),
    .expired_o(hs_expired)
  );

  // All outputs are registered alongside the state they belong to, so every
  // transition below also sets the outputs of the state being entered.
  always_ff @(posedge read_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      st_new_q    <= 1'b0;
      iter_rqst_q <= 1'b0;
      iter_term_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      iter_cnt_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      st_new_q    <= 1'b0;
      iter_term_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (dec_start) begin
            state_q     <= ST_REQ;
            st_new_q    <= 1'b1;
            iter_rqst_q <= 1'b1;
            iter_cnt_q  <= '0;
            err_q       <= 1'b0;
          end
        end
        ST_REQ: begin
          if (busy == BUSY_UPD) begin
            state_q  <= ST_UPD;
            st_new_q <= 1'b1;
          end else if (hs_expired) begin
            state_q     <= ST_ERR;
            iter_rqst_q <= 1'b0;
            iter_term_q <= 1'b1;
            err_q       <= 1'b1;
          end
        end
        ST_UPD: begin
          if (busy == BUSY_FIN) begin
            state_q     <= ST_DROP;
            st_new_q    <= 1'b1;
            iter_rqst_q <= 1'b0;
          end else if ((busy == BUSY_IDLE) || hs_expired) begin
            // busy back to idle without a finish means the writer aborted
            state_q     <= ST_ERR;
            iter_rqst_q <= 1'b0;
            iter_term_q <= 1'b1;
            err_q       <= 1'b1;
          end
        end
        ST_DROP: begin
          if (busy == BUSY_IDLE) begin
            state_q   <= ST_RD;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end else if (hs_expired) begin
            state_q     <= ST_ERR;
            iter_term_q <= 1'b1;
            err_q       <= 1'b1;
          end
        end
        ST_RD: begin
          if (rd_addr_q == AW'(LOAD_CYCLE - 1)) begin
            state_q   <= ST_RD_LAST;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        ST_RD_LAST: begin
          iter_cnt_q <= iter_cnt_q + CW'(1);
          // iter_cnt_q still holds the pre-increment count here
          if (syndrome_ok || (iter_cnt_q == CW'(MAX_ITER - 1))) begin
            state_q     <= ST_TERM;
            iter_term_q <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            state_q     <= ST_REQ;
            st_new_q    <= 1'b1;
            iter_rqst_q <= 1'b1;
          end
        end
        ST_TERM: begin
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign iter_rqst        = iter_rqst_q;
  assign iter_termination = iter_term_q;
  assign ram_read_en      = rd_en_q;
  assign rd_addr          = rd_addr_q;
  assign iter_cnt         = iter_cnt_q;
  assign decode_done      = done_q;
  assign handshake_err    = err_q;
  assign state            = state_q;

endmodule
